// File: rtl/pc_pkg.sv
// ---------------------------------------------------------------------------
// pc_pkg
// Shared definitions for the program-counter / return-address-stack slice:
//   - pc_src_e : next-PC select encodings carried on PCSrc
//   - PC_INC   : sequential increment in bytes
//   - cnt_w()  : width needed to hold an entry count 0..depth
// No ports (package).
// ---------------------------------------------------------------------------
package pc_pkg;

    typedef enum logic [2:0] {
        PC_SEQ    = 3'd0,
        PC_BRANCH = 3'd1,
        PC_JUMP   = 3'd2,
        PC_JREG   = 3'd3,
        PC_CALL   = 3'd4,
        PC_RET    = 3'd5
    } pc_src_e;

    localparam int unsigned PC_INC = 4;

    // Bits needed to represent every count from 0 up to and including depth.
    function automatic int unsigned cnt_w(input int unsigned depth);
        return $clog2(depth + 1);
    endfunction

endpackage

// File: rtl/pc_ras_unit_if.sv
// ---------------------------------------------------------------------------
// pc_ras_unit_if
// Bundles the control inputs and status outputs of pc_ras_unit.
//   master : drives PCWre, PCSrc, BranchOff, JumpTarget, RegTarget;
//            observes Addr, RasCount, RasFull, RasEmpty, Underflow,
//            Illegal, AlignErr
//   slave  : the mirror image, used by pc_ras_unit itself
// Parameters ADDR_W and RAS_DEPTH must match the attached pc_ras_unit.
// ---------------------------------------------------------------------------
interface pc_ras_unit_if #(
    parameter int ADDR_W    = 32,
    parameter int RAS_DEPTH = 4
) ();
    import pc_pkg::*;

    localparam int CNT_W = cnt_w(RAS_DEPTH);

    logic              PCWre;
    logic [2:0]        PCSrc;
    logic [ADDR_W-1:0] BranchOff;
    logic [ADDR_W-1:0] JumpTarget;
    logic [ADDR_W-1:0] RegTarget;
    logic [ADDR_W-1:0] Addr;
    logic [CNT_W-1:0]  RasCount;
    logic              RasFull;
    logic              RasEmpty;
    logic              Underflow;
    logic              Illegal;
    logic              AlignErr;

    modport master (
        output PCWre, PCSrc, BranchOff, JumpTarget, RegTarget,
        input  Addr, RasCount, RasFull, RasEmpty, Underflow, Illegal, AlignErr
    );

    modport slave (
        input  PCWre, PCSrc, BranchOff, JumpTarget, RegTarget,
        output Addr, RasCount, RasFull, RasEmpty, Underflow, Illegal, AlignErr
    );

endinterface

// File: rtl/ras_stack.sv
// ---------------------------------------------------------------------------
// ras_stack
// Circular return-address stack. A push when full overwrites the oldest
// entry, so the stack always holds the newest RAS_DEPTH addresses.
// Ports:
//   clk, rst   : clock, asynchronous active-high reset
//   push       : write push_data as the new top (wins over pop)
//   pop        : discard the top entry (ignored when empty)
//   push_data  : address to push
//   top        : most recently pushed valid entry (undefined when empty)
//   count      : number of valid entries 0..RAS_DEPTH
//   full/empty : count==RAS_DEPTH / count==0
// ---------------------------------------------------------------------------
module ras_stack
    import pc_pkg::*;
#(
    parameter  int ADDR_W    = 32,
    parameter  int RAS_DEPTH = 4,
    localparam int CNT_W     = cnt_w(RAS_DEPTH)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              push,
    input  logic              pop,
    input  logic [ADDR_W-1:0] push_data,
    output logic [ADDR_W-1:0] top,
    output logic [CNT_W-1:0]  count,
    output logic              full,
    output logic              empty
);

    localparam int               PTR_W = $clog2(RAS_DEPTH);
    localparam logic [PTR_W-1:0] LAST  = PTR_W'(RAS_DEPTH - 1);
    localparam logic [CNT_W-1:0] MAX   = CNT_W'(RAS_DEPTH);

    logic [ADDR_W-1:0] mem_q [RAS_DEPTH];
    logic [PTR_W-1:0]  wr_ptr_q, wr_ptr_d;   // slot the next push writes
    logic [PTR_W-1:0]  top_ptr, next_ptr;
    logic [CNT_W-1:0]  count_q, count_d;

    // NOTE: combinational block uses blocking assignments and gives every
    // output a default first, so no path can infer a latch.
    always_comb begin
        top_ptr  = (wr_ptr_q == '0)   ? LAST : wr_ptr_q - 1'b1;
        next_ptr = (wr_ptr_q == LAST) ? '0   : wr_ptr_q + 1'b1;
        wr_ptr_d = wr_ptr_q;
        count_d  = count_q;
        if (push) begin
            wr_ptr_d = next_ptr;
            // Saturate: when full the push replaces the oldest slot.
            if (count_q != MAX) count_d = count_q + 1'b1;
        end else if (pop && count_q != '0) begin
            wr_ptr_d = top_ptr;
            count_d  = count_q - 1'b1;
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge values regardless of statement order.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            count_q  <= count_d;
        end
    end

    // NOTE: the storage array has no reset; entries beyond count are never
    // observed, and a write racing a reset is hidden by the cleared count.
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q] <= push_data;
    end

    assign top   = mem_q[top_ptr];
    assign count = count_q;
    assign full  = (count_q == MAX);
    assign empty = (count_q == '0);

endmodule

// File: rtl/pc_ras_unit.sv
// ---------------------------------------------------------------------------
// pc_ras_unit
// Program counter with branch/jump/call/return selection and a circular
// return-address stack.
// Ports:
//   CLK   : clock, rising edge
//   Reset : asynchronous active-high reset
//   bus   : pc_ras_unit_if.slave
//           PCWre (update enable), PCSrc (next-PC select), BranchOff,
//           JumpTarget, RegTarget in; Addr (current PC), RasCount,
//           RasFull, RasEmpty, Underflow/Illegal (one-cycle pulses),
//           AlignErr (sticky) out
// ---------------------------------------------------------------------------
module pc_ras_unit
    import pc_pkg::*;
#(
    parameter int                ADDR_W    = 32,
    parameter logic [ADDR_W-1:0] RESET_VEC = '0,
    parameter int                RAS_DEPTH = 4
) (
    input  logic         CLK,
    input  logic         Reset,
    pc_ras_unit_if.slave bus
);

    localparam int CNT_W = cnt_w(RAS_DEPTH);

    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              underflow_q, underflow_d;
    logic              illegal_q, illegal_d;
    logic              align_err_q, align_err_d;

    logic [ADDR_W-1:0] pc4;
    logic [ADDR_W-1:0] target;
    logic              push, pop;
    logic [ADDR_W-1:0] stack_top;
    logic [CNT_W-1:0]  stack_count;
    logic              stack_full, stack_empty;

    ras_stack #(
        .ADDR_W    (ADDR_W),
        .RAS_DEPTH (RAS_DEPTH)
    ) u_ras (
        .clk       (CLK),
        .rst       (Reset),
        .push      (push),
        .pop       (pop),
        .push_data (pc4),
        .top       (stack_top),
        .count     (stack_count),
        .full      (stack_full),
        .empty     (stack_empty)
    );

    always_comb begin
        pc4         = addr_q + ADDR_W'(PC_INC);
        target      = pc4;
        push        = 1'b0;
        pop         = 1'b0;
        underflow_d = 1'b0;
        illegal_d   = 1'b0;
        addr_d      = addr_q;
        align_err_d = align_err_q;

        if (bus.PCWre) begin
            case (bus.PCSrc)
                PC_SEQ:    target = pc4;
                PC_BRANCH: target = pc4 + (bus.BranchOff << 2);
                PC_JUMP:   target = bus.JumpTarget;
                PC_JREG:   target = bus.RegTarget;
                PC_CALL: begin
                    target = bus.JumpTarget;
                    push   = 1'b1;
                end
                PC_RET: begin
                    if (!stack_empty) begin
                        target = stack_top;
                        pop    = 1'b1;
                    end else begin
                        // Empty stack: fall back to the register target.
                        target      = bus.RegTarget;
                        underflow_d = 1'b1;
                    end
                end
                default: illegal_d = 1'b1;   // reserved codes behave as SEQ
            endcase

            // Word-align whatever was selected and remember that it was not.
            addr_d = {target[ADDR_W-1:2], 2'b00};
            if (target[1:0] != 2'b00) align_err_d = 1'b1;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            addr_q      <= RESET_VEC;
            underflow_q <= 1'b0;
            illegal_q   <= 1'b0;
            align_err_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            underflow_q <= underflow_d;
            illegal_q   <= illegal_d;
            align_err_q <= align_err_d;
        end
    end

    assign bus.Addr      = addr_q;
    assign bus.RasCount  = stack_count;
    assign bus.RasFull   = stack_full;
    assign bus.RasEmpty  = stack_empty;
    assign bus.Underflow = underflow_q;
    assign bus.Illegal   = illegal_q;
    assign bus.AlignErr  = align_err_q;

endmodule

// File: tb/tb_pc_ras_unit.sv
// ---------------------------------------------------------------------------
// tb_pc_ras_unit
// Directed and random stimulus for pc_ras_unit compared against a
// queue-based reference model of the program counter and return stack.
// ---------------------------------------------------------------------------
module tb_pc_ras_unit;
    import pc_pkg::*;

    localparam int          ADDR_W = 32;
    localparam int          DEPTH  = 4;
    localparam logic [31:0] RVEC   = 32'h100;

    logic CLK = 1'b0;
    logic Reset;

    pc_ras_unit_if #(.ADDR_W(ADDR_W), .RAS_DEPTH(DEPTH)) bus ();

    pc_ras_unit #(
        .ADDR_W    (ADDR_W),
        .RESET_VEC (RVEC),
        .RAS_DEPTH (DEPTH)
    ) dut (
        .CLK   (CLK),
        .Reset (Reset),
        .bus   (bus)
    );

    always #5 CLK = ~CLK;

    int vectors     = 0;
    int miscompares = 0;

    // Reference model state
    logic [31:0] m_pc;
    logic [31:0] m_stack [$];
    bit          m_under, m_ill, m_align;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        if (obs !== exp) begin
            miscompares++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    task automatic model_reset();
        m_pc = RVEC;
        m_stack.delete();
        m_under = 0;
        m_ill   = 0;
        m_align = 0;
    endtask

    task automatic model_step(input bit we, input logic [2:0] src,
                              input logic [31:0] off, input logic [31:0] jt,
                              input logic [31:0] rt);
        logic [31:0] pc4, t;
        m_under = 0;
        m_ill   = 0;
        if (!we) return;
        pc4 = m_pc + 32'd4;
        t   = pc4;
        case (src)
            3'd0: t = pc4;
            3'd1: t = pc4 + off * 4;
            3'd2: t = jt;
            3'd3: t = rt;
            3'd4: begin
                t = jt;
                m_stack.push_back(pc4);
                if (m_stack.size() > DEPTH) void'(m_stack.pop_front());
            end
            3'd5: begin
                if (m_stack.size() != 0) t = m_stack.pop_back();
                else begin
                    t = rt;
                    m_under = 1;
                end
            end
            default: m_ill = 1;
        endcase
        if (t[1:0] != 2'b00) m_align = 1;
        m_pc = t & ~32'd3;
    endtask

    task automatic check_all(input string tag);
        check({tag, ".addr"},  bus.Addr,      m_pc);
        check({tag, ".count"}, bus.RasCount,  m_stack.size());
        check({tag, ".full"},  bus.RasFull,   m_stack.size() == DEPTH);
        check({tag, ".empty"}, bus.RasEmpty,  m_stack.size() == 0);
        check({tag, ".under"}, bus.Underflow, m_under);
        check({tag, ".ill"},   bus.Illegal,   m_ill);
        check({tag, ".align"}, bus.AlignErr,  m_align);
    endtask

    // Apply one set of inputs across one rising edge, then compare.
    task automatic cyc(input string tag, input bit we, input logic [2:0] src,
                       input logic [31:0] off = '0, input logic [31:0] jt = '0,
                       input logic [31:0] rt = '0);
        bus.PCWre      = we;
        bus.PCSrc      = src;
        bus.BranchOff  = off;
        bus.JumpTarget = jt;
        bus.RegTarget  = rt;
        @(posedge CLK);
        model_step(we, src, off, jt, rt);
        #1;
        check_all(tag);
    endtask

    initial begin
        logic [31:0] ret_exp [4];
        ret_exp[0] = 32'h104;
        ret_exp[1] = 32'hC4;
        ret_exp[2] = 32'h84;
        ret_exp[3] = 32'h44;

        Reset          = 1'b1;
        bus.PCWre      = 1'b0;
        bus.PCSrc      = 3'd0;
        bus.BranchOff  = '0;
        bus.JumpTarget = '0;
        bus.RegTarget  = '0;
        model_reset();

        // Reset state, visible before any clock edge
        #2;
        check("rst_addr", bus.Addr, 32'h100);
        check_all("rst_init");
        #10 Reset = 1'b0;

        // Sequential and hold
        cyc("jmp0", 1, PC_JUMP, 0, 32'h0, 0);
        cyc("seq1", 1, PC_SEQ);
        check("seq1_val", bus.Addr, 32'h4);
        cyc("seq2", 1, PC_SEQ);
        check("seq2_val", bus.Addr, 32'h8);
        cyc("seq3", 1, PC_SEQ);
        check("seq3_val", bus.Addr, 32'hC);
        cyc("hold", 0, PC_SEQ);
        check("hold_val", bus.Addr, 32'hC);
        cyc("hold_call", 0, PC_CALL, 0, 32'h80, 0);
        check("hold_cnt", bus.RasCount, 0);

        // Branch backwards and PC wraparound
        cyc("jmp10", 1, PC_JUMP, 0, 32'h10, 0);
        cyc("br_neg", 1, PC_BRANCH, 32'hFFFF_FFFE, 0, 0);
        check("br_neg_val", bus.Addr, 32'hC);
        cyc("jmp_top", 1, PC_JUMP, 0, 32'hFFFF_FFFC, 0);
        cyc("seq_wrap", 1, PC_SEQ);
        check("seq_wrap_val", bus.Addr, 32'h0);

        // Five calls into a four-entry stack, then five returns
        for (int i = 0; i < 5; i++) cyc("call", 1, PC_CALL, 0, 32'((i + 1) * 32'h40), 0);
        check("wrap_full", bus.RasFull, 1'b1);
        check("wrap_cnt", bus.RasCount, DEPTH);
        for (int i = 0; i < 4; i++) begin
            cyc("ret", 1, PC_RET, 0, 0, 32'h200);
            check("ret_val", bus.Addr, ret_exp[i]);
        end
        cyc("ret_empty", 1, PC_RET, 0, 0, 32'h200);
        check("ret_empty_val", bus.Addr, 32'h200);
        check("ret_empty_uf", bus.Underflow, 1'b1);
        cyc("after_uf", 1, PC_SEQ);
        check("uf_pulse_end", bus.Underflow, 1'b0);

        // Misaligned jump and reserved select
        cyc("jmp_mis", 1, PC_JUMP, 0, 32'h23, 0);
        check("jmp_mis_val", bus.Addr, 32'h20);
        check("jmp_mis_ae", bus.AlignErr, 1'b1);
        cyc("ae_sticky", 1, PC_SEQ);
        check("ae_sticky_val", bus.AlignErr, 1'b1);
        cyc("illegal", 1, 3'd7);
        check("illegal_val", bus.Addr, 32'h28);
        check("illegal_pulse", bus.Illegal, 1'b1);
        cyc("after_ill", 1, PC_SEQ);
        check("ill_pulse_end", bus.Illegal, 1'b0);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            logic [31:0] jt, rt, off;
            bit          we;
            we  = ($urandom_range(0, 7) != 0);
            off = 32'($urandom_range(0, 64)) - 32'd32;
            jt  = ($urandom_range(0, 7) == 0) ? $urandom : ($urandom & 32'hFFFF_FFFC);
            rt  = $urandom & 32'hFFFF_FFFC;
            cyc("rand", we, 3'($urandom_range(0, 7)), off, jt, rt);
        end

        // Asynchronous reset mid-run, then a call held under reset
        Reset = 1'b1;
        model_reset();
        #2;
        check("rst_mid_addr", bus.Addr, 32'h100);
        check("rst_mid_cnt", bus.RasCount, 0);
        bus.PCWre      = 1'b1;
        bus.PCSrc      = PC_CALL;
        bus.JumpTarget = 32'h400;
        @(posedge CLK);
        #1;
        check_all("rst_hold");
        #2 Reset = 1'b0;

        cyc("post_rst_seq", 1, PC_SEQ);
        check("post_rst_val", bus.Addr, 32'h104);
        cyc("post_rst_ret", 1, PC_RET, 0, 0, 32'h300);
        check("post_rst_uf", bus.Underflow, 1'b1);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/pc_ras_unit.md
PC_RAS_UNIT -- requirements
Module: pc_ras_unit

Interface
REQ-001 SHALL have parameter ADDR_W, default 32, program-counter width in bits.
REQ-002 SHALL have parameter RESET_VEC, default 0, Addr value after reset.
REQ-003 SHALL have parameter RAS_DEPTH, default 4, return-address-stack entries (>=2).
REQ-004 SHALL have port CLK  input  1  sole clock, rising edge.
REQ-005 SHALL have port Reset  input  1  asynchronous, active-high reset.
REQ-006 SHALL have port PCWre  input  1  PC write enable; 0 = hold all state.
REQ-007 SHALL have port PCSrc  input  3  next-PC select: 0 SEQ, 1 BRANCH, 2 JUMP, 3 JREG, 4 CALL, 5 RET, 6-7 reserved.
REQ-008 SHALL have port BranchOff  input  ADDR_W  signed word offset for BRANCH.
REQ-009 SHALL have port JumpTarget  input  ADDR_W  byte target for JUMP/CALL.
REQ-010 SHALL have port RegTarget  input  ADDR_W  byte target for JREG; fallback for RET on empty stack.
REQ-011 SHALL have port Addr  output  ADDR_W  current PC, registered.
REQ-012 SHALL have port RasCount  output  clog2(RAS_DEPTH+1)  valid stack entries.
REQ-013 SHALL have port RasFull/RasEmpty  output  1 each  RasCount==RAS_DEPTH / ==0.
REQ-014 SHALL have port Underflow, Illegal  output  1 each  one-cycle pulses, registered.
REQ-015 SHALL have port AlignErr  output  1  sticky misaligned-target flag.

Function
REQ-016 SHALL update Addr only on a rising CLK edge with PCWre=1; PCWre=0 holds Addr, stack, and clears pulses.
REQ-017 SHALL compute PC4 = Addr+4 modulo 2^ADDR_W; SEQ loads PC4.
REQ-018 SHALL load BRANCH as PC4 + (BranchOff<<2), modulo 2^ADDR_W, overflow discarded.
REQ-019 SHALL load JUMP with JumpTarget and JREG with RegTarget.
REQ-020 SHALL on CALL load JumpTarget and push PC4 in the same edge.
REQ-021 SHALL on CALL with RasFull overwrite the oldest entry (circular), RasCount staying RAS_DEPTH.
REQ-022 SHALL on RET with RasCount>0 load the most recent entry and pop it.
REQ-023 SHALL on RET with RasEmpty load RegTarget, leave stack unchanged, pulse Underflow for one cycle.
REQ-024 SHALL treat PCSrc 6/7 as SEQ and pulse Illegal for one cycle.
REQ-025 SHALL, when the selected target has bits[1:0]!=0, load it with bits[1:0] cleared and set AlignErr until Reset.
REQ-026 SHALL have single-cycle latency: new Addr visible immediately after the enabling edge.
REQ-027 SHALL preserve LIFO order across wrap: after DEPTH+1 calls, DEPTH returns yield the newest DEPTH addresses newest-first.

Reset
REQ-028 SHALL on Reset=1 asynchronously force Addr=RESET_VEC, RasCount=0, RasEmpty=1, RasFull=0, Underflow=Illegal=AlignErr=0.
REQ-029 SHALL hold reset values while Reset=1 regardless of PCWre; mid-call reset discards the push.
REQ-030 SHALL resume normal operation on the first rising edge after Reset deasserts.

Structure
REQ-031 SHALL place PCSrc encodings, the increment constant 4, and a width helper in shared package pc_pkg.
REQ-032 SHALL implement the stack as sub-module ras_stack (push, pop, top, count, circular pointer), parametrised by ADDR_W and RAS_DEPTH.

Verification
REQ-033 SHALL verify reset: Reset=1 mid-run with RESET_VEC=0x100 -> Addr=0x100 without clock edge, RasCount=0.
REQ-034 SHALL verify sequence/hold: PCWre=1 SEQ x3 from 0 -> 4,8,0xC; PCWre=0 one cycle -> Addr stays 0xC.
REQ-035 SHALL verify branch: Addr=0x10, BranchOff=-2 -> Addr=0x0C; Addr=0xFFFFFFFC SEQ -> 0x0.
REQ-036 SHALL verify stack wrap: DEPTH=4, five CALLs from 0x0,0x40,0x80,0xC0,0x100 (targets +0x40) then five RETs -> 0x104,0xC4,0x84,0x44, then RegTarget with Underflow=1.
REQ-037 SHALL verify errors: JUMP to 0x23 -> Addr=0x20, AlignErr=1 persisting; PCSrc=7 -> SEQ with Illegal one-cycle pulse.
